// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - issue, ALU and result signal bundle for alu_issue_ctrl
// Ports (slave = controller view):
//   in_valid/in_ready, instr, pc, rs1_data, rs2_data : instruction issue handshake
//   alu_opcode, alu_op_0, alu_op_1                   : drive to the combinational ALU
//   alu_out, alu_zero, alu_negative                  : ALU return
//   res_valid/res_ready, res_data, res_rd, res_we,
//   res_branch_taken, res_branch_target, res_illegal : result handshake
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_op_0;
  logic [31:0] alu_op_1;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_negative;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we;
  logic        res_branch_taken;
  logic [31:0] res_branch_target;
  logic        res_illegal;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data,
    input  alu_out, alu_zero, alu_negative, res_ready,
    output in_ready, alu_opcode, alu_op_0, alu_op_1,
    output res_valid, res_data, res_rd, res_we, res_branch_taken, res_branch_target, res_illegal
  );

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data,
    output alu_out, alu_zero, alu_negative, res_ready,
    input  in_ready, alu_opcode, alu_op_0, alu_op_1,
    input  res_valid, res_data, res_rd, res_we, res_branch_taken, res_branch_target, res_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32 decode and settle-timed issue front end for a combinational ALU
// Purpose: accepts one instruction, decodes it to an ALU opcode/operands, holds them for
//   SETTLE_CYCLES, captures the ALU result and presents a writeback or branch decision.
// Ports: clock, reset (asynchronous, active-high), bus (alu_issue_ctrl_if.slave).
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clock,
  input  logic            reset,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SLL = 3'b101, OP_SRL = 3'b110, OP_SRA = 3'b111
  } alu_op_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic        accept, capture;
  logic        in_ready_q;
  logic [3:0]  cnt_q;

  // Instruction fields
  logic [6:0]  f_opc, f_f7;
  logic [2:0]  f_f3;
  logic [4:0]  f_rd;
  logic        f7_zero, f7_alt;
  logic [31:0] imm_i, imm_b, shamt;
  logic        unused_rs1_idx;

  assign f_opc   = bus.instr[6:0];
  assign f_f3    = bus.instr[14:12];
  assign f_f7    = bus.instr[31:25];
  assign f_rd    = bus.instr[11:7];
  assign f7_zero = (f_f7 == 7'b0000000);
  assign f7_alt  = (f_f7 == 7'b0100000);
  assign imm_i   = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_b   = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign shamt   = {27'd0, bus.instr[24:20]};
  // Register indices arrive already resolved in rs1_data/rs2_data.
  assign unused_rs1_idx = ^bus.instr[19:15];

  // Decode
  alu_op_t     d_op;
  logic        d_legal, d_branch;
  logic [31:0] d_op_1;

  always_comb begin
    d_op     = OP_ADD;
    d_legal  = 1'b0;
    d_branch = 1'b0;
    d_op_1   = bus.rs2_data;
    case (f_opc)
      7'b0110011: begin
        d_legal = 1'b1;
        case (f_f3)
          3'b000: if (f7_zero) d_op = OP_ADD; else if (f7_alt) d_op = OP_SUB; else d_legal = 1'b0;
          3'b001: begin d_op = OP_SLL; d_legal = f7_zero; end
          3'b100: begin d_op = OP_XOR; d_legal = f7_zero; end
          3'b101: if (f7_zero) d_op = OP_SRL; else if (f7_alt) d_op = OP_SRA; else d_legal = 1'b0;
          3'b110: begin d_op = OP_OR;  d_legal = f7_zero; end
          3'b111: begin d_op = OP_AND; d_legal = f7_zero; end
          default: d_legal = 1'b0;
        endcase
      end
      7'b0010011: begin
        d_legal = 1'b1;
        d_op_1  = imm_i;
        case (f_f3)
          3'b000: d_op = OP_ADD;
          3'b100: d_op = OP_XOR;
          3'b110: d_op = OP_OR;
          3'b111: d_op = OP_AND;
          3'b001: begin d_op = OP_SLL; d_op_1 = shamt; d_legal = f7_zero; end
          3'b101: begin
            d_op_1 = shamt;
            if (f7_zero) d_op = OP_SRL; else if (f7_alt) d_op = OP_SRA; else d_legal = 1'b0;
          end
          default: d_legal = 1'b0;
        endcase
      end
      7'b1100011: begin
        // BEQ/BNE/BLT/BGE all have f3[1]=0; BLTU/BGEU and the reserved codes do not.
        d_branch = 1'b1;
        d_op     = OP_SUB;
        d_legal  = ~f_f3[1];
      end
      default: d_legal = 1'b0;
    endcase
  end

  // FSM
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin accept = 1'b1; state_d = EXEC; end
      EXEC: if (cnt_q == 4'd0) begin capture = 1'b1; state_d = DONE; end
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue registers
  logic [2:0]  opcode_q;
  logic [31:0] op_0_q, op_1_q, target_q;
  logic [4:0]  rd_q;
  logic        we_q, branch_q, illegal_q, br_lt_q, br_inv_q;

  // Result registers
  logic [31:0] res_data_q, res_target_q;
  logic [4:0]  res_rd_q;
  logic        res_we_q, res_taken_q, res_illegal_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready_q    <= 1'b0;
      cnt_q         <= 4'd0;
      opcode_q      <= OP_ADD;
      op_0_q        <= 32'd0;
      op_1_q        <= 32'd0;
      target_q      <= 32'd0;
      rd_q          <= 5'd0;
      we_q          <= 1'b0;
      branch_q      <= 1'b0;
      illegal_q     <= 1'b0;
      br_lt_q       <= 1'b0;
      br_inv_q      <= 1'b0;
      res_data_q    <= 32'd0;
      res_target_q  <= 32'd0;
      res_rd_q      <= 5'd0;
      res_we_q      <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
    end else begin
      // Registered from the next state, so in_ready stays low through the DONE-exit cycle.
      in_ready_q <= (state_d == IDLE);
      if (accept) begin
        cnt_q     <= SETTLE_LOAD;
        // Illegal instructions park the ALU on ADD 0,0.
        opcode_q  <= d_legal ? d_op : OP_ADD;
        op_0_q    <= d_legal ? bus.rs1_data : 32'd0;
        op_1_q    <= d_legal ? d_op_1 : 32'd0;
        we_q      <= d_legal && !d_branch && (f_rd != 5'd0);
        rd_q      <= (d_legal && !d_branch) ? f_rd : 5'd0;
        branch_q  <= d_legal && d_branch;
        illegal_q <= !d_legal;
        target_q  <= (d_legal && d_branch) ? (bus.pc + imm_b) : 32'd0;
        br_lt_q   <= f_f3[2];
        br_inv_q  <= f_f3[0];
      end else if (state_q == EXEC && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        res_data_q    <= (illegal_q || branch_q) ? 32'd0 : bus.alu_out;
        res_rd_q      <= rd_q;
        res_we_q      <= we_q;
        // f3[2] selects the sign test (BLT/BGE) over equality; f3[0] inverts (BNE/BGE).
        res_taken_q   <= branch_q && ((br_lt_q ? bus.alu_negative : bus.alu_zero) ^ br_inv_q);
        res_target_q  <= target_q;
        res_illegal_q <= illegal_q;
      end
    end
  end

  assign bus.in_ready          = in_ready_q;
  assign bus.res_valid         = (state_q == DONE);
  assign bus.alu_opcode        = opcode_q;
  assign bus.alu_op_0          = op_0_q;
  assign bus.alu_op_1          = op_1_q;
  assign bus.res_data          = res_data_q;
  assign bus.res_rd            = res_rd_q;
  assign bus.res_we            = res_we_q;
  assign bus.res_branch_taken  = res_taken_q;
  assign bus.res_branch_target = res_target_q;
  assign bus.res_illegal       = res_illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  localparam int S4 = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  alu_issue_ctrl_if b4 ();
  alu_issue_ctrl_if b1 ();

  alu_issue_ctrl #(.SETTLE_CYCLES(S4)) u_dut4 (.clock(clock), .reset(reset), .bus(b4));
  alu_issue_ctrl #(.SETTLE_CYCLES(1))  u_dut1 (.clock(clock), .reset(reset), .bus(b1));

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return $signed(a) >>> b[4:0];
    endcase
  endfunction

  assign b4.alu_out      = alu_f(b4.alu_opcode, b4.alu_op_0, b4.alu_op_1);
  assign b4.alu_zero     = (b4.alu_out == 32'd0);
  assign b4.alu_negative = b4.alu_out[31];
  assign b1.alu_out      = alu_f(b1.alu_opcode, b1.alu_op_0, b1.alu_op_1);
  assign b1.alu_zero     = (b1.alu_out == 32'd0);
  assign b1.alu_negative = b1.alu_out[31];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the instruction means, computed directly.
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, data, target;
    logic [4:0]  rd;
    logic        we, taken, ill;
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [31:0] immi = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] immb = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [4:0]  sh = ins[24:20];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] diff = x - y;
    bit ok = 1'b1;
    bit br = 1'b0;
    e = '{default: '0};
    if (ins[6:0] == 7'h33) begin
      e.a = x; e.b = y;
      case ({f7, f3})
        {7'h00, 3'd0}: begin e.op = 0; e.data = x + y; end
        {7'h20, 3'd0}: begin e.op = 1; e.data = x - y; end
        {7'h00, 3'd1}: begin e.op = 5; e.data = x << y[4:0]; end
        {7'h00, 3'd4}: begin e.op = 4; e.data = x ^ y; end
        {7'h00, 3'd5}: begin e.op = 6; e.data = x >> y[4:0]; end
        {7'h20, 3'd5}: begin e.op = 7; e.data = $signed(x) >>> y[4:0]; end
        {7'h00, 3'd6}: begin e.op = 3; e.data = x | y; end
        {7'h00, 3'd7}: begin e.op = 2; e.data = x & y; end
        default: ok = 1'b0;
      endcase
    end else if (ins[6:0] == 7'h13) begin
      e.a = x; e.b = immi;
      if (f3 == 3'd0) begin e.op = 0; e.data = x + immi; end
      else if (f3 == 3'd4) begin e.op = 4; e.data = x ^ immi; end
      else if (f3 == 3'd6) begin e.op = 3; e.data = x | immi; end
      else if (f3 == 3'd7) begin e.op = 2; e.data = x & immi; end
      else if (f3 == 3'd1 && f7 == 7'h00) begin e.op = 5; e.b = {27'd0, sh}; e.data = x << sh; end
      else if (f3 == 3'd5 && f7 == 7'h00) begin e.op = 6; e.b = {27'd0, sh}; e.data = x >> sh; end
      else if (f3 == 3'd5 && f7 == 7'h20) begin e.op = 7; e.b = {27'd0, sh}; e.data = $signed(x) >>> sh; end
      else ok = 1'b0;
    end else if (ins[6:0] == 7'h63) begin
      br = 1'b1; e.op = 1; e.a = x; e.b = y; e.target = p + immb;
      if (f3 == 3'd0) e.taken = (x == y);
      else if (f3 == 3'd1) e.taken = (x != y);
      else if (f3 == 3'd4) e.taken = diff[31];
      else if (f3 == 3'd5) e.taken = !diff[31];
      else ok = 1'b0;
    end else ok = 1'b0;
    if (!ok) begin
      e = '{default: '0};
      e.ill = 1'b1;
    end else if (!br) begin
      e.rd = ins[11:7];
      e.we = (e.rd != 5'd0);
    end
    return e;
  endfunction

  // Transaction-level timeline of the S4 instance.
  bit   m_rdy = 1'b0, m_pend = 1'b0, m_valid = 1'b0;
  int   m_since = 0;
  exp_t ea = '{default: '0};
  exp_t er = '{default: '0};
  exp_t cur;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_rdy = 1'b0; m_pend = 1'b0; m_valid = 1'b0; m_since = 0;
      ea = '{default: '0};
      er = '{default: '0};
    end else if (m_valid) begin
      if (b4.res_ready) begin m_valid = 1'b0; m_rdy = 1'b1; end
    end else if (m_pend) begin
      m_since++;
      if (m_since == S4) begin m_pend = 1'b0; m_valid = 1'b1; er = cur; end
    end else if (m_rdy && b4.in_valid) begin
      cur = model(b4.instr, b4.pc, b4.rs1_data, b4.rs2_data);
      ea = cur; m_pend = 1'b1; m_since = 0; m_rdy = 1'b0;
    end else begin
      m_rdy = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("in_ready", b4.in_ready, m_rdy);
      cmp("res_valid", b4.res_valid, m_valid);
      cmp("alu_opcode", b4.alu_opcode, ea.op);
      cmp("alu_op_0", b4.alu_op_0, ea.a);
      cmp("alu_op_1", b4.alu_op_1, ea.b);
      cmp("res_data", b4.res_data, er.data);
      cmp("res_rd", b4.res_rd, er.rd);
      cmp("res_we", b4.res_we, er.we);
      cmp("res_taken", b4.res_branch_taken, er.taken);
      cmp("res_target", b4.res_branch_target, er.target);
      cmp("res_illegal", b4.res_illegal, er.ill);
    end
  end

  logic [31:0] cap_data, cap_target, cap_op1;
  logic [4:0]  cap_rd;
  logic [2:0]  cap_op;
  logic        cap_we, cap_taken, cap_ill, cap_rdy;

  task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b, input int hold);
    int n;
    @(posedge clock); #1;
    b4.instr = i; b4.pc = p; b4.rs1_data = a; b4.rs2_data = b;
    b4.in_valid = 1'b1; b4.res_ready = 1'b0;
    n = 0;
    while (!b4.in_ready && n < 50) begin @(posedge clock); #1; n++; end
    cmp("accept_wait", (n < 50), 1);
    @(posedge clock); #1;
    // Keep in_valid high with junk so a wrongful accept while busy shows up.
    b4.instr = $urandom; b4.rs1_data = $urandom; b4.rs2_data = $urandom;
    n = 0;
    while (!b4.res_valid && n < 40) begin @(posedge clock); #1; n++; end
    cmp("result_wait", (n < 40), 1);
    cap_data = b4.res_data; cap_rd = b4.res_rd; cap_we = b4.res_we;
    cap_taken = b4.res_branch_taken; cap_target = b4.res_branch_target;
    cap_ill = b4.res_illegal; cap_op = b4.alu_opcode; cap_op1 = b4.alu_op_1;
    cap_rdy = b4.in_ready;
    repeat (hold) begin @(posedge clock); #1; end
    b4.res_ready = 1'b1;
    @(posedge clock); #1;
    b4.res_ready = 1'b0; b4.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0] opc, f7;
    int k = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0, 1: f7 = 7'h00;
      2: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case (k)
      0, 1, 2: opc = 7'h33;
      3, 4, 5: opc = 7'h13;
      6, 7: opc = 7'h63;
      8: opc = 7'($urandom);
      default: return $urandom;
    endcase
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  localparam logic [31:0] I_ADD  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
  localparam logic [31:0] I_SRAI = {7'h20, 5'd4, 5'd1, 3'd5, 5'd4, 7'h13};
  localparam logic [31:0] I_BEQ  = {1'b1, 6'h3f, 5'd2, 5'd1, 3'd0, 4'hc, 1'b1, 7'h63};
  localparam logic [31:0] I_BLT  = {1'b1, 6'h3f, 5'd2, 5'd1, 3'd4, 4'hc, 1'b1, 7'h63};
  localparam logic [31:0] I_SLT  = {7'h00, 5'd2, 5'd1, 3'd2, 5'd5, 7'h33};
  localparam logic [31:0] I_ADDI0 = {12'd5, 5'd1, 3'd0, 5'd0, 7'h13};

  initial begin
    exp_t e;
    int n;
    bit seen;
    logic [31:0] a, b;
    reset = 1'b1;
    b4.in_valid = 0; b4.instr = 0; b4.pc = 0; b4.rs1_data = 0; b4.rs2_data = 0; b4.res_ready = 0;
    b1.in_valid = 0; b1.instr = 0; b1.pc = 0; b1.rs1_data = 0; b1.rs2_data = 0; b1.res_ready = 0;

    // Pin the reference model against hand-worked values.
    e = model(I_ADD, 32'h0, 32'd5, 32'd7);
    cmp("model_add_data", e.data, 32'd12);
    cmp("model_add_rd", e.rd, 5'd3);
    e = model(I_BEQ, 32'h100, 32'd9, 32'd9);
    cmp("model_beq_target", e.target, 32'h000000F8);
    cmp("model_beq_taken", e.taken, 1);
    e = model(I_SRAI, 32'h0, 32'h80000000, 32'h0);
    cmp("model_srai_data", e.data, 32'hF8000000);

    repeat (2) @(negedge clock);
    cmp("rst_in_ready", b4.in_ready, 0);
    cmp("rst_res_valid", b4.res_valid, 0);
    cmp("rst_opcode", b4.alu_opcode, 0);
    cmp("rst_res_data", b4.res_data, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clock); #1;
    cmp("in_ready_after_release", b4.in_ready, 1);

    // SETTLE_CYCLES=1 latency on the second instance.
    b1.instr = I_ADD; b1.rs1_data = 32'd5; b1.rs2_data = 32'd7; b1.in_valid = 1'b1;
    n = 0;
    while (!b1.in_ready && n < 20) begin @(posedge clock); #1; n++; end
    cmp("s1_accept_wait", (n < 20), 1);
    @(posedge clock); #1;
    b1.in_valid = 1'b0;
    cmp("s1_exec_valid", b1.res_valid, 0);
    cmp("s1_opcode", b1.alu_opcode, 3'b000);
    cmp("s1_op0", b1.alu_op_0, 32'd5);
    cmp("s1_op1", b1.alu_op_1, 32'd7);
    @(posedge clock); #1;
    cmp("s1_res_valid", b1.res_valid, 1);
    cmp("s1_res_data", b1.res_data, 32'd12);
    cmp("s1_res_rd", b1.res_rd, 5'd3);
    cmp("s1_res_we", b1.res_we, 1);
    cmp("s1_in_ready_done", b1.in_ready, 0);
    b1.res_ready = 1'b1;
    @(posedge clock); #1;
    b1.res_ready = 1'b0;
    cmp("s1_valid_dropped", b1.res_valid, 0);
    cmp("s1_in_ready_idle", b1.in_ready, 1);

    // Directed cases on the S4 instance.
    issue(I_SRAI, 32'h0, 32'h80000000, 32'h0, 0);
    cmp("srai_data", cap_data, 32'hF8000000);
    cmp("srai_opcode", cap_op, 3'b111);
    cmp("srai_op1", cap_op1, 32'd4);
    issue(I_BEQ, 32'h100, 32'd9, 32'd9, 1);
    cmp("beq_opcode", cap_op, 3'b001);
    cmp("beq_taken", cap_taken, 1);
    cmp("beq_target", cap_target, 32'h000000F8);
    cmp("beq_we", cap_we, 0);
    issue(I_BLT, 32'h100, 32'd3, 32'd9, 0);
    cmp("blt_taken", cap_taken, 1);
    issue(I_SLT, 32'h0, 32'd1, 32'd2, 0);
    cmp("slt_illegal", cap_ill, 1);
    cmp("slt_we", cap_we, 0);
    cmp("slt_data", cap_data, 32'd0);
    issue(I_ADDI0, 32'h0, 32'd10, 32'd0, 5);
    cmp("addi_x0_we", cap_we, 0);
    cmp("addi_x0_rd", cap_rd, 5'd0);
    cmp("addi_x0_data", cap_data, 32'd15);
    cmp("backpressure_in_ready", cap_rdy, 0);

    // Reset in the middle of EXEC.
    @(posedge clock); #1;
    b4.instr = I_ADD; b4.rs1_data = 32'h1234; b4.rs2_data = 32'd1; b4.in_valid = 1'b1;
    n = 0;
    while (!b4.in_ready && n < 50) begin @(posedge clock); #1; n++; end
    cmp("rst_accept_wait", (n < 50), 1);
    @(posedge clock); #1;
    b4.in_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    cmp("abort_res_valid", b4.res_valid, 0);
    cmp("abort_op0", b4.alu_op_0, 32'd0);
    cmp("abort_res_data", b4.res_data, 32'd0);
    cmp("abort_in_ready", b4.in_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    cmp("abort_in_ready_release", b4.in_ready, 1);
    seen = 1'b0;
    repeat (10) begin @(posedge clock); #1; if (b4.res_valid) seen = 1'b1; end
    cmp("abort_no_result", seen, 0);

    // Randomized traffic.
    for (int t = 0; t < 150; t++) begin
      a = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      issue(gen_instr(), $urandom, a, b, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end

    @(negedge clock);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
